imem_arb: RTL and testbench
===========================

IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 256, number of 32-bit words in the instruction memory.
REQ-002 SHALL have parameter MAX_WAIT, default 4, consecutive denied load cycles before load gets priority.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port fetch_req  input  1  CPU fetch read request.
REQ-006 SHALL have port fetch_addr  input  32  CPU word address.
REQ-007 SHALL have ports fetch_gnt, fetch_rvalid, fetch_err  output  1 each  grant, read data valid, out-of-range flag.
REQ-008 SHALL have port fetch_rdata  output  32  read data to CPU.
REQ-009 SHALL have ports load_req, load_we, load_lock  input  1 each  loader request, write enable, exclusive-ownership request.
REQ-010 SHALL have ports load_addr, load_wdata  input  32 each  loader word address, write data.
REQ-011 SHALL have ports load_gnt, load_rvalid, load_err, locked  output  1 each  grant, read valid, out-of-range flag, lock state.
REQ-012 SHALL have port load_rdata  output  32  read data to loader.
REQ-013 SHALL have ports mem_en, mem_we  output  1 each  memory access strobe, write strobe.
REQ-014 SHALL have ports mem_addr  output  $clog2(MEM_SIZE)  and mem_wdata  output  32.
REQ-015 SHALL have port mem_rdata  input  32  memory read data, valid the cycle after mem_en with mem_we=0.

Function
REQ-016 SHALL implement states RUN and LOCK; RUN on reset.
REQ-017 In RUN, SHALL grant at most one requester per cycle: fetch over load, unless wait_cnt == MAX_WAIT, then load wins.
REQ-018 wait_cnt SHALL increment (saturating at MAX_WAIT) each cycle load_req=1 and load_gnt=0; clear to 0 on load_gnt=1 or load_req=0.
REQ-019 In LOCK, SHALL never assert fetch_gnt; load_req SHALL be granted every cycle it is high.
REQ-020 RUN->LOCK on a rising edge with load_lock=1; LOCK->RUN on a rising edge with load_lock=0; locked=1 exactly in LOCK.
REQ-021 Grants SHALL be combinational in the request cycle; mem_en, mem_we, mem_addr, mem_wdata driven combinationally from the granted requester.
REQ-022 An in-range read grant SHALL assert the owner's rvalid exactly one cycle later with rdata=mem_rdata, err=0.
REQ-023 An address >= MEM_SIZE SHALL still be granted, SHALL NOT assert mem_en; a read returns rvalid=1, rdata=0, err=1 one cycle later; a write is dropped silently.
REQ-024 A granted write (load_we=1, in range) SHALL assert mem_en=1, mem_we=1 and produce no rvalid.
REQ-025 fetch_we does not exist; fetch port SHALL be read-only.
REQ-026 Back-to-back grants SHALL sustain one access per cycle; the response-owner/err register SHALL pipeline so responses never collide.
REQ-027 With no grant, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-028 rdata of a port with rvalid=0 SHALL be 0.
REQ-029 load_lock asserted in the same cycle as fetch_req in RUN: fetch granted that cycle; its response still delivered next cycle in LOCK.

Reset
REQ-030 reset=1 SHALL immediately force RUN, wait_cnt=0, all grants, rvalid, err, locked, mem_en, mem_we=0, all data outputs 0.
REQ-031 A response pending at reset SHALL be discarded; no rvalid after reset deasserts for a pre-reset grant.

Verification
REQ-032 Fetch read addr 5, mem_rdata=0x2402000A next cycle -> fetch_gnt=1 cycle N, fetch_rvalid=1, fetch_rdata=0x2402000A, fetch_err=0 cycle N+1.
REQ-033 fetch_req and load_req held high 6 cycles -> fetch granted cycles 0-3, load granted cycle 4, wait_cnt back to 0, fetch granted cycle 5.
REQ-034 load_lock=1, then load write addr 10 data 0xDEADBEEF with fetch_req=1 -> locked=1, mem_we=1, mem_addr=10, fetch_gnt=0 while locked.
REQ-035 Fetch read addr 300 -> mem_en=0, next cycle fetch_rvalid=1, fetch_rdata=0, fetch_err=1.
REQ-036 Fetch granted, reset pulsed before next edge -> all outputs 0, no fetch_rvalid afterwards, state RUN.
REQ-037 load_lock and fetch_req rise same cycle -> fetch_gnt=1 that cycle, fetch_rvalid=1 next cycle with locked=1.

Source files
------------

// File: rtl/imem_arb.sv
// imem_arb: arbitrates a read-only CPU fetch port and a read/write loader port
// onto a single-ported instruction memory.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   fetch_req/addr               CPU read request and word address
//   fetch_gnt/rvalid/rdata/err   CPU grant and one-cycle-later read response
//   load_req/we/lock/addr/wdata  loader request, write enable, exclusive lock
//   load_gnt/rvalid/rdata/err    loader grant and read response
//   locked                       high while the loader owns the memory
//   mem_en/we/addr/wdata         memory strobes, driven from the granted port
//   mem_rdata                    memory read data, valid one cycle after a read
module imem_arb #(
  parameter int MEM_SIZE = 256,
  parameter int MAX_WAIT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fetch_req,
  input  logic [31:0]                 fetch_addr,
  output logic                        fetch_gnt,
  output logic                        fetch_rvalid,
  output logic                        fetch_err,
  output logic [31:0]                 fetch_rdata,
  input  logic                        load_req,
  input  logic                        load_we,
  input  logic                        load_lock,
  input  logic [31:0]                 load_addr,
  input  logic [31:0]                 load_wdata,
  output logic                        load_gnt,
  output logic                        load_rvalid,
  output logic                        load_err,
  output logic                        locked,
  output logic [31:0]                 load_rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
  output logic [31:0]                 mem_wdata,
  input  logic [31:0]                 mem_rdata
);

  localparam int AW = $clog2(MEM_SIZE);
  localparam int WW = $clog2(MAX_WAIT + 2);
  localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

  typedef enum logic {RUN = 1'b0, LOCK = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          rd_fetch_p0, rd_load_p0, oor_p0;
  logic          rsp_fetch_p1, rsp_load_p1, rsp_err_p1;

  function automatic logic in_range(input logic [31:0] a);
    return a < 32'(MEM_SIZE);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Stage p0: grant decision and memory strobes, all in the request cycle.
  // Reset gates everything so outputs drop to zero without waiting for an edge.
  always_comb begin
    state_nxt   = state;
    wait_nxt    = '0;
    fetch_gnt   = 1'b0;
    load_gnt    = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    oor_p0      = 1'b0;
    rd_fetch_p0 = 1'b0;
    rd_load_p0  = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (load_lock) state_nxt = LOCK;
          // The loader wins only once it has been starved MAX_WAIT cycles.
          if (fetch_req && !(load_req && wait_cnt == WAIT_LIM)) fetch_gnt = 1'b1;
          else                                                   load_gnt  = load_req;
        end
        LOCK: begin
          if (!load_lock) state_nxt = RUN;
          load_gnt = load_req;
        end
        default: state_nxt = RUN;
      endcase

      if (fetch_gnt) begin
        oor_p0      = !in_range(fetch_addr);
        mem_en      = !oor_p0;
        mem_addr    = oor_p0 ? '0 : fetch_addr[AW-1:0];
        rd_fetch_p0 = 1'b1;
      end else if (load_gnt) begin
        oor_p0     = !in_range(load_addr);
        mem_en     = !oor_p0;
        mem_we     = !oor_p0 && load_we;
        mem_addr   = oor_p0 ? '0 : load_addr[AW-1:0];
        mem_wdata  = (!oor_p0 && load_we) ? load_wdata : '0;
        // Out-of-range writes are dropped and produce no response at all.
        rd_load_p0 = !load_we;
      end

      if (load_req && !load_gnt)
        wait_nxt = (wait_cnt == WAIT_LIM) ? wait_cnt : wait_cnt + WW'(1);
    end
  end

  // Stage p1: response owner and error flag, one entry per cycle so
  // back-to-back grants never overlap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_fetch_p1 <= 1'b0;
      rsp_load_p1  <= 1'b0;
      rsp_err_p1   <= 1'b0;
    end else begin
      rsp_fetch_p1 <= rd_fetch_p0;
      rsp_load_p1  <= rd_load_p0;
      rsp_err_p1   <= oor_p0 && (rd_fetch_p0 || rd_load_p0);
    end
  end

  assign fetch_rvalid = rsp_fetch_p1;
  assign fetch_err    = rsp_fetch_p1 && rsp_err_p1;
  assign fetch_rdata  = (rsp_fetch_p1 && !rsp_err_p1) ? mem_rdata : '0;
  assign load_rvalid  = rsp_load_p1;
  assign load_err     = rsp_load_p1 && rsp_err_p1;
  assign load_rdata   = (rsp_load_p1 && !rsp_err_p1) ? mem_rdata : '0;
  assign locked       = (state == LOCK);

endmodule

// File: tb/tb_imem_arb.sv
module tb_imem_arb;
  localparam int MEM_SIZE = 256;
  localparam int MAX_WAIT = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req, load_req, load_we, load_lock;
  logic [31:0]   fetch_addr, load_addr, load_wdata, mem_rdata;
  logic          fetch_gnt, fetch_rvalid, fetch_err;
  logic [31:0]   fetch_rdata, load_rdata, mem_wdata;
  logic          load_gnt, load_rvalid, load_err, locked, mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  imem_arb #(.MEM_SIZE(MEM_SIZE), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_err(fetch_err), .fetch_rdata(fetch_rdata),
    .load_req(load_req), .load_we(load_we), .load_lock(load_lock),
    .load_addr(load_addr), .load_wdata(load_wdata), .load_gnt(load_gnt),
    .load_rvalid(load_rvalid), .load_err(load_err), .locked(locked),
    .load_rdata(load_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Inputs change 1 time unit after a rising edge; checks happen mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_req = 0; fetch_addr = 0; load_req = 0; load_we = 0;
    load_lock = 0; load_addr = 0; load_wdata = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    idle();
    fetch_req = 1; load_req = 1; load_addr = 3; fetch_addr = 4; load_lock = 1;
    #2;
    total++;
    if ({fetch_gnt, load_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_comb: gnt=%b%b en=%b we=%b addr=%0d wdata=%h want all 0",
               fetch_gnt, load_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    total++;
    if ({fetch_rvalid, load_rvalid, fetch_err, load_err, locked} !== 5'b0 ||
        fetch_rdata !== 0 || load_rdata !== 0) begin
      bad++;
      $display("FAIL reset_regs: rv=%b%b err=%b%b locked=%b want 0",
               fetch_rvalid, load_rvalid, fetch_err, load_err, locked);
    end
    tick();
    reset = 0;
    idle();
    #4;
    total++;
    if (locked !== 1'b0 || fetch_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: locked=%b rvalid=%b want 0 0", locked, fetch_rvalid);
    end
    tick();
  endtask

  task automatic test_fetch_read();
    idle();
    fetch_req = 1; fetch_addr = 5;
    #4;
    total++;
    if ({fetch_gnt, load_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 8'd5) begin
      bad++;
      $display("FAIL fetch_grant: gnt=%b%b en=%b we=%b addr=%0d want 1 0 1 0 5",
               fetch_gnt, load_gnt, mem_en, mem_we, mem_addr);
    end
    tick();
    idle();
    mem_rdata = 32'h2402000A;
    #4;
    total++;
    if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h2402000A || fetch_err !== 1'b0 ||
        load_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL fetch_resp: rvalid=%b rdata=%h err=%b lrv=%b want 1 2402000a 0 0",
               fetch_rvalid, fetch_rdata, fetch_err, load_rvalid);
    end
    total++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL idle_mem: en=%b we=%b addr=%0d wdata=%h want 0", mem_en, mem_we,
               mem_addr, mem_wdata);
    end
    tick();
    mem_rdata = 32'h1234_5678;
    #4;
    total++;
    if (fetch_rvalid !== 1'b0 || fetch_rdata !== 32'h0) begin
      bad++;
      $display("FAIL rdata_zero: rvalid=%b rdata=%h want 0 0", fetch_rvalid, fetch_rdata);
    end
    tick();
  endtask

  task automatic test_starvation();
    idle();
    fetch_req = 1; fetch_addr = 1; load_req = 1; load_addr = 7;
    for (int c = 0; c < 6; c++) begin
      #4;
      total++;
      if (fetch_gnt !== (c != 4) || load_gnt !== (c == 4)) begin
        bad++;
        $display("FAIL starve_c%0d: fetch_gnt=%b load_gnt=%b want %b %b", c, fetch_gnt,
                 load_gnt, c != 4, c == 4);
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_lock_write();
    idle();
    load_lock = 1;
    tick();
    load_req = 1; load_we = 1; load_addr = 10; load_wdata = 32'hDEADBEEF;
    fetch_req = 1; fetch_addr = 3;
    #4;
    total++;
    if ({locked, load_gnt, fetch_gnt, mem_en, mem_we} !== 5'b11011 ||
        mem_addr !== 8'd10 || mem_wdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL lock_write: lk=%b lg=%b fg=%b en=%b we=%b a=%0d d=%h want 1 1 0 1 1 10 deadbeef",
               locked, load_gnt, fetch_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick();
    load_req = 0; load_we = 0;
    #4;
    total++;
    if (fetch_gnt !== 1'b0 || load_rvalid !== 1'b0 || fetch_rvalid !== 1'b0 || locked !== 1'b1) begin
      bad++;
      $display("FAIL lock_hold: fg=%b lrv=%b frv=%b lk=%b want 0 0 0 1", fetch_gnt,
               load_rvalid, fetch_rvalid, locked);
    end
    load_lock = 0;
    tick();
    #4;
    total++;
    if (locked !== 1'b0 || fetch_gnt !== 1'b1) begin
      bad++;
      $display("FAIL unlock: locked=%b fetch_gnt=%b want 0 1", locked, fetch_gnt);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_out_of_range();
    idle();
    fetch_req = 1; fetch_addr = 300;
    #4;
    total++;
    if (fetch_gnt !== 1'b1 || mem_en !== 1'b0) begin
      bad++;
      $display("FAIL oor_grant: gnt=%b en=%b want 1 0", fetch_gnt, mem_en);
    end
    tick();
    idle();
    mem_rdata = 32'hCAFEF00D;
    load_req = 1; load_we = 1; load_addr = 1000; load_wdata = 32'h55;
    #4;
    total++;
    if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h0 || fetch_err !== 1'b1) begin
      bad++;
      $display("FAIL oor_resp: rvalid=%b rdata=%h err=%b want 1 0 1", fetch_rvalid,
               fetch_rdata, fetch_err);
    end
    total++;
    if (load_gnt !== 1'b1 || mem_en !== 1'b0 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL oor_write: gnt=%b en=%b we=%b want 1 0 0", load_gnt, mem_en, mem_we);
    end
    tick();
    idle();
    #4;
    total++;
    if (load_rvalid !== 1'b0 || load_err !== 1'b0) begin
      bad++;
      $display("FAIL oor_write_resp: rvalid=%b err=%b want 0 0", load_rvalid, load_err);
    end
    tick();
  endtask

  task automatic test_reset_pending();
    idle();
    fetch_req = 1; fetch_addr = 5;
    #4;
    total++;
    if (fetch_gnt !== 1'b1) begin
      bad++;
      $display("FAIL pend_grant: gnt=%b want 1", fetch_gnt);
    end
    #1;
    reset = 1;
    #1;
    total++;
    if ({fetch_gnt, load_gnt, mem_en, mem_we, mem_addr, mem_wdata, fetch_rvalid,
         load_rvalid, locked} !== '0) begin
      bad++;
      $display("FAIL pend_reset: fg=%b en=%b a=%0d frv=%b lk=%b want 0", fetch_gnt,
               mem_en, mem_addr, fetch_rvalid, locked);
    end
    tick();
    reset = 0;
    idle();
    mem_rdata = 32'h0BAD_0BAD;
    for (int c = 0; c < 2; c++) begin
      #4;
      total++;
      if (fetch_rvalid !== 1'b0 || fetch_rdata !== 32'h0) begin
        bad++;
        $display("FAIL pend_dropped_c%0d: rvalid=%b rdata=%h want 0 0", c, fetch_rvalid,
                 fetch_rdata);
      end
      tick();
    end
    fetch_req = 1; fetch_addr = 2;
    #4;
    total++;
    if (fetch_gnt !== 1'b1 || locked !== 1'b0) begin
      bad++;
      $display("FAIL pend_run: fetch_gnt=%b locked=%b want 1 0", fetch_gnt, locked);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_lock_same_cycle();
    idle();
    fetch_req = 1; fetch_addr = 20; load_lock = 1;
    #4;
    total++;
    if (fetch_gnt !== 1'b1 || locked !== 1'b0) begin
      bad++;
      $display("FAIL samecyc_grant: fetch_gnt=%b locked=%b want 1 0", fetch_gnt, locked);
    end
    tick();
    fetch_req = 0;
    mem_rdata = 32'hA5A5_0001;
    #4;
    total++;
    if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'hA5A5_0001 || locked !== 1'b1) begin
      bad++;
      $display("FAIL samecyc_resp: rvalid=%b rdata=%h locked=%b want 1 a5a50001 1",
               fetch_rvalid, fetch_rdata, locked);
    end
    load_lock = 0;
    tick();
    idle();
    tick();
  endtask

  // Reference model: who should own the memory this cycle follows directly
  // from the arbitration rules; the model remembers only lock ownership,
  // the loader's starvation count and the one outstanding response.
  task automatic test_random();
    bit m_lock = 0;
    int m_wait = 0;
    bit pend_f = 0, pend_l = 0, pend_err = 0;
    bit lock_in = 0;
    idle();
    tick();
    for (int n = 0; n < 600; n++) begin
      bit eg_f, eg_l, inr;
      logic [31:0] a;
      logic [43:0] exp_mem, got_mem;
      logic [68:0] exp_rsp, got_rsp;
      if ($urandom_range(0, 99) < 6) lock_in = !lock_in;
      fetch_req  = ($urandom_range(0, 1) == 1);
      load_req   = ($urandom_range(0, 1) == 1);
      load_we    = ($urandom_range(0, 9) < 3);
      load_lock  = lock_in;
      fetch_addr = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h100) : $urandom_range(0, MEM_SIZE - 1);
      load_addr  = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h100) : $urandom_range(0, MEM_SIZE - 1);
      load_wdata = $urandom;
      mem_rdata  = $urandom;
      #4;
      if (m_lock) begin
        eg_f = 0; eg_l = load_req;
      end else if (fetch_req && !(load_req && m_wait == MAX_WAIT)) begin
        eg_f = 1; eg_l = 0;
      end else begin
        eg_f = 0; eg_l = load_req;
      end
      a   = eg_f ? fetch_addr : (eg_l ? load_addr : 32'd0);
      inr = (a < MEM_SIZE);
      exp_mem = '0;
      if ((eg_f || eg_l) && inr) begin
        exp_mem[43]    = 1'b1;
        exp_mem[42]    = eg_l && load_we;
        exp_mem[41:34] = a[7:0];
        exp_mem[31:0]  = (eg_l && load_we) ? load_wdata : 32'd0;
      end
      exp_mem[33] = eg_f;
      exp_mem[32] = eg_l;
      got_mem = {mem_en, mem_we, mem_addr, fetch_gnt, load_gnt, mem_wdata};
      total++;
      if (got_mem !== exp_mem) begin
        bad++;
        $display("FAIL rand_mem_%0d: got en/we/addr/fg/lg/wdata=%h want %h", n, got_mem, exp_mem);
      end
      exp_rsp = {pend_f, pend_l, pend_f && pend_err, pend_l && pend_err, m_lock,
                 (pend_f && !pend_err) ? mem_rdata : 32'd0,
                 (pend_l && !pend_err) ? mem_rdata : 32'd0};
      got_rsp = {fetch_rvalid, load_rvalid, fetch_err, load_err, locked, fetch_rdata, load_rdata};
      total++;
      if (got_rsp !== exp_rsp) begin
        bad++;
        $display("FAIL rand_rsp_%0d: got rv/err/lock/rdata=%h want %h", n, got_rsp, exp_rsp);
      end
      pend_f   = eg_f;
      pend_l   = eg_l && !load_we;
      pend_err = !inr;
      m_wait   = (load_req && !eg_l) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
      m_lock   = lock_in;
      tick();
    end
    idle();
    tick();
    tick();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_fetch_read();
    test_starvation();
    test_lock_write();
    test_out_of_range();
    test_reset_pending();
    test_lock_same_cycle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
